// File: rtl/mem_responder_pkg.sv
// ============================================================================
// mem_responder_pkg : shared constants for the CPU memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  localparam logic [7:0] ADDR_SW  = 8'hFE;
  localparam logic [7:0] ADDR_LED = 8'hFF;

  localparam int DATA_W = 16;
  localparam int LED_W  = 10;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_responder_ram.sv
// ============================================================================
// ram_sp16 : single-port synchronous RAM, write-enable, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_sp16 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Output register only moves on an enabled read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) r_mem[addr] <= wdata;
      else    rdata       <= r_mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : RAM + switch/LED I/O responder for the CPU req/ack bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_ack,
  input  logic [9:0]        sw_in,
  output logic [9:0]        led_out
);

  localparam logic [ADDR_W-1:0] c_addr_sw  = ADDR_W'(ADDR_SW);
  localparam logic [ADDR_W-1:0] c_addr_led = ADDR_W'(ADDR_LED);
  localparam logic [CNT_W-1:0]  c_cnt_load = CNT_W'(WAIT_STATES - 1);
  localparam bit                c_no_wait  = (WAIT_STATES == 0);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [LED_W-1:0]    r_sw_meta;
  logic [LED_W-1:0]    r_sw_sync;
  logic                r_rd_ram;
  logic [DATA_W-1:0]   r_io_rdata;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_enter_ack;
  logic                w_is_sw;
  logic                w_is_led;
  logic                w_is_ram;
  logic                w_ram_en;
  logic [DATA_W-1:0]   w_ram_q;

  // With zero wait states the access completes on the same edge it is seen,
  // so the live bus is used instead of the (not yet loaded) capture regs.
  always_comb begin
    w_addr  = (r_state == ST_IDLE) ? mem_addr  : r_addr;
    w_wr    = (r_state == ST_IDLE) ? mem_wr    : r_wr;
    w_wdata = (r_state == ST_IDLE) ? mem_wdata : r_wdata;
    w_enter_ack = mem_req &&
                  (((r_state == ST_IDLE) && c_no_wait) ||
                   ((r_state == ST_WAIT) && (r_cnt == '0)));
    w_is_sw  = (w_addr == c_addr_sw);
    w_is_led = (w_addr == c_addr_led);
    w_is_ram = !(w_is_sw || w_is_led);
    w_ram_en = w_enter_ack && !reset && w_is_ram;
  end

  ram_sp16 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_wr),
    .addr  (w_addr),
    .wdata (w_wdata),
    .rdata (w_ram_q)
  );

  assign mem_rdata = r_rd_ram ? w_ram_q : r_io_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      mem_ack    <= 1'b0;
      led_out    <= '0;
      r_rd_ram   <= 1'b0;
      r_io_rdata <= '0;
    end else begin
      mem_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_addr  <= mem_addr;
            r_wr    <= mem_wr;
            r_wdata <= mem_wdata;
            if (c_no_wait) begin
              r_state <= ST_ACK;
              mem_ack <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= c_cnt_load;
            end
          end
        end
        ST_WAIT: begin
          if (!mem_req) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= ST_ACK;
            mem_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Side effects of the access land on the edge that enters ACK.
      if (w_enter_ack) begin
        if (w_wr) begin
          if (w_is_led) led_out <= w_wdata[LED_W-1:0];
        end else if (w_is_ram) begin
          r_rd_ram <= 1'b1;
        end else begin
          r_rd_ram   <= 1'b0;
          r_io_rdata <= w_is_sw ? {6'b0, r_sw_sync} : {6'b0, led_out};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed bench for mem_responder at 0, 2 and 3 wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [3];
  logic        wr    [3];
  logic [7:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ack   [3];
  logic [9:0]  led   [3];
  logic [9:0]  sw;

  int ws [3] = '{0, 2, 3};

  logic [15:0] mmem [3][256];
  logic [15:0] exp_rdata [3];
  logic        exp_ack   [3];
  logic [9:0]  exp_led   [3];
  logic [9:0]  sw_at [4096];
  int          cyc = 0;
  int          last_ack [3];
  int          prev_ack [3];
  int          req_cyc  [3];
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_STATES(0), .ADDR_W(8)) u_ws0 (
    .clk(clk), .reset(rst), .mem_req(req[0]), .mem_wr(wr[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]), .sw_in(sw), .led_out(led[0]));
  mem_responder #(.WAIT_STATES(2), .ADDR_W(8)) u_ws2 (
    .clk(clk), .reset(rst), .mem_req(req[1]), .mem_wr(wr[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]), .sw_in(sw), .led_out(led[1]));
  mem_responder #(.WAIT_STATES(3), .ADDR_W(8)) u_ws3 (
    .clk(clk), .reset(rst), .mem_req(req[2]), .mem_wr(wr[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ack(ack[2]), .sw_in(sw), .led_out(led[2]));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Switch history as seen at each rising edge, for the synchronizer model.
  always @(posedge clk) begin
    sw_at[cyc[11:0]] = sw;
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i] === 1'b1) begin
        prev_ack[i] = last_ack[i];
        last_ack[i] = cyc;
      end
      if (chk_en) begin
        chk($sformatf("ack%0d", i),   16'(ack[i]), 16'(exp_ack[i]));
        chk($sformatf("rdata%0d", i), rdata[i],    exp_rdata[i]);
        chk($sformatf("led%0d", i),   16'(led[i]), 16'(exp_led[i]));
      end
    end
  end

  // One bus access; from_ack means it starts while the previous ack is high,
  // so the first edge is not sampled. hold keeps req high after the ack.
  task automatic access(input int i, input bit w, input logic [7:0] a,
                        input logic [15:0] d, input bit hold, input bit from_ack);
    int n;
    logic [11:0] si;
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
    req_cyc[i] = cyc;
    n = (from_ack ? 2 : 1) + ws[i];
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_ack[i] = 1'b0;
    end
    exp_ack[i] = 1'b1;
    if (w) begin
      if (a == 8'hFF)      exp_led[i] = d[9:0];
      else if (a != 8'hFE) mmem[i][a] = d;
    end else begin
      si = 12'(cyc - 3);
      if (a == 8'hFF)      exp_rdata[i] = {6'b0, exp_led[i]};
      else if (a == 8'hFE) exp_rdata[i] = {6'b0, sw_at[si]};
      else                 exp_rdata[i] = mmem[i][a];
    end
    if (!hold) begin
      req[i] = 1'b0;
      @(posedge clk); #1;
      exp_ack[i] = 1'b0;
    end
  endtask

  // Write abandoned on the last wait cycle, by dropping req or by reset.
  task automatic abort_wr(input int i, input logic [7:0] a, input logic [15:0] d,
                          input bit by_reset);
    req[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; wdata[i] = d;
    for (int k = 0; k < ws[i]; k++) begin
      @(posedge clk); #1;
    end
    if (by_reset) rst = 1'b1;
    else          req[i] = 1'b0;
    @(posedge clk); #1;
    req[i] = 1'b0;
    rst = 1'b0;
    if (by_reset) begin
      for (int j = 0; j < 3; j++) begin
        exp_rdata[j] = '0;
        exp_led[j]   = '0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      exp_rdata[i] = '0; exp_ack[i] = 1'b0; exp_led[i] = '0;
      last_ack[i] = 0; prev_ack[i] = 0; req_cyc[i] = 0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_rdata", rdata[0], 16'h0000);
    chk("reset_ack",   16'(ack[2]), 16'h0000);
    chk("reset_led",   16'(led[1]), 16'h0000);

    // Zero wait states: write then read back
    access(0, 1'b1, 8'h10, 16'h1234, 1'b0, 1'b0);
    chk("ws0_wr_latency", 16'(last_ack[0] - req_cyc[0]), 16'd1);
    access(0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    chk("ws0_rd_latency", 16'(last_ack[0] - req_cyc[0]), 16'd1);
    chk("ws0_rd_data", rdata[0], 16'h1234);
    chk("ws0_led_idle", 16'(led[0]), 16'h0000);

    // Three wait states: latency and rdata holding through a write
    access(2, 1'b1, 8'h10, 16'hA5A5, 1'b0, 1'b0);
    access(2, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    chk("ws3_rd_latency", 16'(last_ack[2] - req_cyc[2]), 16'd4);
    chk("ws3_rd_data", rdata[2], 16'hA5A5);
    access(2, 1'b1, 8'h10, 16'h5555, 1'b0, 1'b0);
    chk("ws3_rdata_hold", rdata[2], 16'hA5A5);

    // LED register and the read-only switch word
    access(0, 1'b1, 8'hFF, 16'h03FF, 1'b0, 1'b0);
    chk("led_3ff", 16'(led[0]), 16'h03FF);
    access(0, 1'b1, 8'hFF, 16'hFC05, 1'b0, 1'b0);
    chk("led_005", 16'(led[0]), 16'h0005);
    access(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0);
    chk("led_readback", rdata[0], 16'h0005);
    access(0, 1'b1, 8'hFE, 16'h1234, 1'b0, 1'b0);
    chk("sw_write_ignored", 16'(led[0]), 16'h0005);

    // Switch synchronizer
    sw = 10'h2A5;
    repeat (2) @(posedge clk);
    #1;
    access(0, 1'b0, 8'hFE, 16'h0000, 1'b0, 1'b0);
    chk("sw_read", rdata[0], 16'h02A5);
    sw = 10'h3C3;
    @(posedge clk); #1;
    access(0, 1'b0, 8'hFE, 16'h0000, 1'b0, 1'b0);
    chk("sw_too_late", rdata[0], 16'h02A5);
    access(0, 1'b0, 8'hFE, 16'h0000, 1'b0, 1'b0);
    chk("sw_settled", rdata[0], 16'h03C3);

    // Aborted writes with two wait states
    access(1, 1'b1, 8'h20, 16'h1111, 1'b0, 1'b0);
    abort_wr(1, 8'h20, 16'hBEEF, 1'b0);
    access(1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0);
    chk("abort_drop_data", rdata[1], 16'h1111);
    abort_wr(1, 8'h20, 16'hBEEF, 1'b1);
    chk("abort_rst_rdata", rdata[1], 16'h0000);
    chk("abort_rst_led", 16'(led[0]), 16'h0000);
    access(1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0);
    chk("abort_rst_data", rdata[1], 16'h1111);

    // Back-to-back write/read with req held high
    access(0, 1'b1, 8'h30, 16'hC0DE, 1'b1, 1'b0);
    access(0, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b1);
    chk("b2b_ws0_gap", 16'(last_ack[0] - prev_ack[0]), 16'd2);
    chk("b2b_ws0_data", rdata[0], 16'hC0DE);
    access(2, 1'b1, 8'h30, 16'h7E57, 1'b1, 1'b0);
    access(2, 1'b0, 8'h30, 16'h0000, 1'b0, 1'b1);
    chk("b2b_ws3_gap", 16'(last_ack[2] - prev_ack[2]), 16'd5);
    chk("b2b_ws3_data", rdata[2], 16'h7E57);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
